// File: rtl/dec_rr_scheduler_pkg.sv
// Shared definitions for the round-robin decrement scheduler: default
// sizes and the round-robin search helper.
package dec_rr_scheduler_pkg;

  localparam int W_DEF = 4;
  localparam int N_DEF = 4;

  // Returns the first set index of elig at or after ptr, wrapping modulo n
  // (n a power of 2), or -1 when nothing is set.
  function automatic int rr_first(input logic [31:0] elig, input int ptr, input int n);
    int idx;
    rr_first = -1;
    for (int k = n - 1; k >= 0; k--) begin
      idx = (ptr + k) & (n - 1);
      if (elig[idx[4:0]]) rr_first = idx;
    end
  endfunction

endpackage

// File: rtl/dec_borrow_chain.sv
// Ripple-borrow decrementer: S = X - 1, Bo[i] is the borrow out of bit i.
module dec_borrow_chain #(
  parameter int W = 4
) (
  input  logic [W-1:0] X,
  output logic [W-1:0] S,
  output logic [W-1:0] Bo
);

  logic w_b;

  always_comb begin
    w_b = 1'b1;
    S   = '0;
    Bo  = '0;
    for (int i = 0; i < W; i++) begin
      S[i]  = X[i] ^ w_b;
      Bo[i] = ~X[i] & w_b;
      w_b   = Bo[i];
    end
  end

endmodule

// File: rtl/dec_rr_scheduler.sv
// N channel down-counters sharing one decrementer; a round-robin arbiter
// grants one requesting non-zero channel per cycle.
module dec_rr_scheduler
  import dec_rr_scheduler_pkg::*;
#(
  parameter  int W  = W_DEF,
  parameter  int N  = N_DEF,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [CW-1:0] load_ch,
  input  logic [W-1:0]  load_val,
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] rd_ch,
  output logic [W-1:0]  rd_val,
  output logic [N-1:0]  grant,
  output logic          dec_valid,
  output logic [W-1:0]  dec_val,
  output logic [N-1:0]  zero,
  output logic [N-1:0]  done
);

  logic [W-1:0]  r_count [N];
  logic [CW-1:0] r_ptr;
  logic [N-1:0]  r_grant;
  logic          r_dec_valid;
  logic [W-1:0]  r_dec_val;
  logic [N-1:0]  r_done;

  logic [N-1:0]  w_zero;
  logic [N-1:0]  w_elig;
  int            w_pick;
  logic          w_any;
  logic [CW-1:0] w_g;
  logic [W-1:0]  w_dec_out;
  logic [W-1:0]  w_unused_bo;

  // A channel being loaded this cycle sits out arbitration: the load wins.
  always_comb begin
    w_zero = '0;
    w_elig = '0;
    for (int i = 0; i < N; i++) begin
      w_zero[i] = (r_count[i] == '0);
      w_elig[i] = req[i] & ~w_zero[i] & ~(load_en && (load_ch == CW'(i)));
    end
    w_pick = rr_first(32'(w_elig), 32'(r_ptr), N);
    w_any  = (w_pick >= 0);
    w_g    = w_pick[CW-1:0];
  end

  // Borrow-out is never consumed: a zero channel cannot be granted.
  dec_borrow_chain #(.W(W)) u_dec (
    .X  (r_count[w_g]),
    .S  (w_dec_out),
    .Bo (w_unused_bo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_count[i] <= '0;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_dec_valid <= 1'b0;
      r_dec_val   <= '0;
      r_done      <= '0;
    end else begin
      if (w_any) begin
        r_count[w_g] <= w_dec_out;
        r_ptr        <= w_g + CW'(1);
        r_grant      <= N'(1) << w_g;
        r_dec_valid  <= 1'b1;
        r_dec_val    <= w_dec_out;
        r_done       <= (r_count[w_g] == W'(1)) ? (N'(1) << w_g) : '0;
      end else begin
        r_grant     <= '0;
        r_dec_valid <= 1'b0;
        r_done      <= '0;
      end
      if (load_en) r_count[load_ch] <= load_val;
    end
  end

  assign rd_val    = r_count[rd_ch];
  assign zero      = w_zero;
  assign grant     = r_grant;
  assign dec_valid = r_dec_valid;
  assign dec_val   = r_dec_val;
  assign done      = r_done;

endmodule
